// File: rtl/video_pkg.sv
// Shared video timing constants and capture FSM state type, common to the
// frame grabber and the monitor read-back path.
`timescale 1ns/1ps
package video_pkg;

  localparam int H_ACTIVE = 604;
  localparam int V_ACTIVE = 412;

  // Sync and blank windows, in pixel clocks / lines, shared with the monitor
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/video_edge_det.sv
// Edge detector for vsync and vid_blank; the previous sample only advances on
// pix_en, so edges are measured between consecutive pixel samples.
`timescale 1ns/1ps
module video_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic pix_en,
  input  logic vsync,
  input  logic vid_blank,
  output logic vsync_fall,
  output logic blank_rise,
  output logic blank_fall
);

  logic vsync_prev;
  logic blank_prev;

  // vsync idles high, so its history resets high to avoid a false fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_prev <= 1'b1;
      blank_prev <= 1'b0;
    end else if (pix_en) begin
      vsync_prev <= vsync;
      blank_prev <= vid_blank;
    end
  end

  assign vsync_fall = pix_en & vsync_prev & ~vsync;
  assign blank_rise = pix_en & ~blank_prev & vid_blank;
  assign blank_fall = pix_en & blank_prev & ~vid_blank;

endmodule

// File: rtl/frame_capture.sv
// Video-in frame grabber: packs pixel pairs into 16-bit words, even lines to
// the low bank and odd lines to the high bank, each with its own address.
`timescale 1ns/1ps
module frame_capture #(
  parameter int H_ACTIVE = 604,
  parameter int V_ACTIVE = 412,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_en,
  input  logic              vsync,
  input  logic              hsync,
  input  logic              vid_blank,
  input  logic [7:0]        video_in,
  input  logic              start,
  input  logic              abort,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [9:0]        lines_captured
);

  import video_pkg::*;

  localparam logic [10:0] H_MAX  = 11'(H_ACTIVE);
  localparam logic [9:0]  V_MAX  = 10'(V_ACTIVE);
  localparam logic [10:0] CNT_SAT = 11'h7FF;

  cap_state_t state, state_nxt;

  logic              vsync_fall, blank_rise, blank_fall;
  logic              phase, line_idx;
  logic [7:0]        lo_byte;
  logic [10:0]       pix_cnt;
  logic [ADDR_W-1:0] addr_lo, addr_hi;

  logic        capt, line_end, line_valid, in_range, phase_cur;
  logic        wr_en, start_ok, arm_go, frame_end;
  logic [10:0] cnt_cur;
  logic [9:0]  lines_next;
  logic [15:0] wr_data;

  // hsync is a timing reference only; capture is framed by vsync/vid_blank
  logic unused_hsync;
  assign unused_hsync = hsync;

  video_edge_det u_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .vsync      (vsync),
    .vid_blank  (vid_blank),
    .vsync_fall (vsync_fall),
    .blank_rise (blank_rise),
    .blank_fall (blank_fall)
  );

  // Event decode; a line start restarts the pixel count and pairing
  always_comb begin
    capt       = (state == ST_CAPTURE) && !abort;
    cnt_cur    = blank_rise ? 11'd0 : pix_cnt;
    phase_cur  = blank_rise ? 1'b0 : phase;
    in_range   = cnt_cur < H_MAX;
    line_end   = capt && blank_fall;
    line_valid = line_end && (pix_cnt != 11'd0);
    lines_next = lines_captured + {9'd0, line_valid};
    frame_end  = capt && (vsync_fall || (line_valid && (lines_next == V_MAX)));
    start_ok   = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
    arm_go     = (state == ST_ARMED) && !abort && vsync_fall;
    wr_en      = 1'b0;
    wr_data    = pack_word(video_in, lo_byte);
    if (capt && pix_en) begin
      if (line_end) begin
        wr_en   = phase;
        wr_data = pack_word(8'h00, lo_byte);
      end else begin
        wr_en   = vid_blank && in_range && phase_cur;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_ok)  state_nxt = ST_ARMED;
      ST_ARMED:   if (arm_go)    state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (frame_end) state_nxt = ST_DONE;
      ST_DONE:    if (start_ok)  state_nxt = ST_ARMED;
      default:                   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  assign busy = (state == ST_ARMED) || (state == ST_CAPTURE);

  // Packer, bank address counters and frame status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we         <= 1'b0;
      mem_bank       <= 1'b0;
      mem_addr       <= '0;
      mem_data       <= 16'h0000;
      done           <= 1'b0;
      frame_err      <= 1'b0;
      lines_captured <= 10'd0;
      phase          <= 1'b0;
      line_idx       <= 1'b0;
      lo_byte        <= 8'h00;
      pix_cnt        <= 11'd0;
      addr_lo        <= '0;
      addr_hi        <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        done           <= 1'b0;
        frame_err      <= 1'b0;
        lines_captured <= 10'd0;
      end
      if (arm_go) begin
        addr_lo  <= '0;
        addr_hi  <= '0;
        line_idx <= 1'b0;
        phase    <= 1'b0;
        pix_cnt  <= 11'd0;
      end
      if (capt && pix_en) begin
        if (line_end) begin
          if (line_valid) begin
            lines_captured <= lines_next;
            line_idx       <= ~line_idx;
            if (pix_cnt < H_MAX) frame_err <= 1'b1;
          end
          if (phase) frame_err <= 1'b1;
          pix_cnt <= 11'd0;
          phase   <= 1'b0;
        end else if (vid_blank) begin
          if (in_range) begin
            if (!phase_cur) lo_byte <= video_in;
            phase <= ~phase_cur;
          end else begin
            phase     <= phase_cur;
            frame_err <= 1'b1;
          end
          pix_cnt <= (cnt_cur == CNT_SAT) ? cnt_cur : cnt_cur + 11'd1;
        end
      end
      if (wr_en) begin
        mem_we   <= 1'b1;
        mem_bank <= line_idx;
        mem_addr <= line_idx ? addr_hi : addr_lo;
        mem_data <= wr_data;
        if (line_idx) addr_hi <= addr_hi + ADDR_W'(1);
        else          addr_lo <= addr_lo + ADDR_W'(1);
      end
      if (frame_end) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture: pixel samples every other clock, outputs
// checked on the falling edge following each sample.
`timescale 1ns/1ps
module tb_frame_capture;

  logic        clk = 1'b0;
  logic        reset_n, pix_en, vsync, hsync, vid_blank, start, abort;
  logic [7:0]  video_in;
  logic        mem_we, mem_bank, busy, done, frame_err;
  logic [15:0] mem_addr, mem_data;
  logic [9:0]  lines_captured;

  int n_chk  = 0;
  int n_fail = 0;
  int wr0 = 0, wr1 = 0;
  logic [15:0] last0 = 16'h0, last1 = 16'h0;
  int snap0, snap1;

  always #10 clk = ~clk;

  frame_capture dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pix_en         (pix_en),
    .vsync          (vsync),
    .hsync          (hsync),
    .vid_blank      (vid_blank),
    .video_in       (video_in),
    .start          (start),
    .abort          (abort),
    .mem_we         (mem_we),
    .mem_bank       (mem_bank),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .busy           (busy),
    .done           (done),
    .frame_err      (frame_err),
    .lines_captured (lines_captured)
  );

  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      if (mem_bank) begin wr1++; last1 = mem_addr; end
      else          begin wr0++; last0 = mem_addr; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic smp(input logic vs, input logic bl, input logic [7:0] d);
    @(negedge clk);
    pix_en = 1'b1; vsync = vs; vid_blank = bl; video_in = d;
    hsync = bl;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) smp(1'b1, 1'b1, 8'(i));
    smp(1'b1, 1'b0, 8'h00);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic arm_and_sync();
    pulse_start();
    smp(1'b1, 1'b0, 8'h00);
    smp(1'b0, 1'b0, 8'h00);
    smp(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; pix_en = 1'b0; vsync = 1'b1; hsync = 1'b1; vid_blank = 1'b0;
    video_in = 8'h00; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_bank",  32'(mem_bank), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_data",  32'(mem_data), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(frame_err), 32'd0);
    chk("rst_lines", 32'(lines_captured), 32'd0);
    reset_n = 1'b1;

    // Full 4-line frame of 604-pixel ramps
    pulse_start();
    chk("armed_busy", 32'(busy), 32'd1);
    snap0 = wr0; snap1 = wr1;
    smp(1'b1, 1'b0, 8'h00);
    smp(1'b0, 1'b0, 8'h00);
    smp(1'b1, 1'b0, 8'h00);
    smp(1'b1, 1'b1, 8'h00);
    chk("f1_w0_we", 32'(mem_we), 32'd0);
    smp(1'b1, 1'b1, 8'h01);
    chk("f1_w0_we2",  32'(mem_we), 32'd1);
    chk("f1_w0_data", 32'(mem_data), 32'h0100);
    chk("f1_w0_addr", 32'(mem_addr), 32'd0);
    chk("f1_w0_bank", 32'(mem_bank), 32'd0);
    for (int i = 2; i < 604; i++) smp(1'b1, 1'b1, 8'(i));
    smp(1'b1, 1'b0, 8'h00);
    send_line(604);
    send_line(604);
    send_line(604);
    smp(1'b0, 1'b0, 8'h00);
    chk("f1_done",  32'(done), 32'd1);
    chk("f1_busy",  32'(busy), 32'd0);
    chk("f1_lines", 32'(lines_captured), 32'd4);
    chk("f1_err",   32'(frame_err), 32'd0);
    chk("f1_cnt0",  32'(wr0 - snap0), 32'd604);
    chk("f1_cnt1",  32'(wr1 - snap1), 32'd604);
    chk("f1_last0", 32'(last0), 32'd603);
    chk("f1_last1", 32'(last1), 32'd603);

    // Five-pixel line with odd-pixel flush, then a two-pixel odd line
    pulse_start();
    chk("s_done_clr", 32'(done), 32'd0);
    chk("s_lines_clr", 32'(lines_captured), 32'd0);
    smp(1'b1, 1'b0, 8'h00);
    smp(1'b0, 1'b0, 8'h00);
    smp(1'b1, 1'b0, 8'h00);
    smp(1'b1, 1'b1, 8'h11);
    chk("s_p1_we", 32'(mem_we), 32'd0);
    smp(1'b1, 1'b1, 8'h22);
    chk("s_w0_we",   32'(mem_we), 32'd1);
    chk("s_w0_data", 32'(mem_data), 32'h2211);
    chk("s_w0_addr", 32'(mem_addr), 32'd0);
    smp(1'b1, 1'b1, 8'h33);
    smp(1'b1, 1'b1, 8'h44);
    chk("s_w1_data", 32'(mem_data), 32'h4433);
    chk("s_w1_addr", 32'(mem_addr), 32'd1);
    smp(1'b1, 1'b1, 8'h55);
    smp(1'b1, 1'b0, 8'h00);
    chk("s_fl_we",   32'(mem_we), 32'd1);
    chk("s_fl_data", 32'(mem_data), 32'h0055);
    chk("s_fl_addr", 32'(mem_addr), 32'd2);
    chk("s_err",     32'(frame_err), 32'd1);
    chk("s_lines",   32'(lines_captured), 32'd1);
    smp(1'b1, 1'b1, 8'hAA);
    smp(1'b1, 1'b1, 8'hBB);
    chk("s_hi_bank", 32'(mem_bank), 32'd1);
    chk("s_hi_addr", 32'(mem_addr), 32'd0);
    chk("s_hi_data", 32'(mem_data), 32'hBBAA);
    smp(1'b1, 1'b0, 8'h00);
    smp(1'b0, 1'b0, 8'h00);
    chk("s_done", 32'(done), 32'd1);

    // Over-long line: extra pixels dropped
    pulse_start();
    chk("l_err_clr", 32'(frame_err), 32'd0);
    smp(1'b1, 1'b0, 8'h00);
    smp(1'b0, 1'b0, 8'h00);
    smp(1'b1, 1'b0, 8'h00);
    snap0 = wr0;
    send_line(610);
    chk("l_writes", 32'(wr0 - snap0), 32'd302);
    chk("l_err",    32'(frame_err), 32'd1);
    smp(1'b0, 1'b0, 8'h00);

    // Abort mid-line 2, then restart
    arm_and_sync();
    send_line(10);
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b1, 8'(i));
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("a_busy", 32'(busy), 32'd0);
    chk("a_done", 32'(done), 32'd0);
    snap0 = wr0; snap1 = wr1;
    for (int i = 4; i < 10; i++) smp(1'b1, 1'b1, 8'(i));
    smp(1'b1, 1'b0, 8'h00);
    chk("a_nowr", 32'((wr0 - snap0) + (wr1 - snap1)), 32'd0);
    arm_and_sync();
    smp(1'b1, 1'b1, 8'h01);
    smp(1'b1, 1'b1, 8'h02);
    chk("a_lo_bank", 32'(mem_bank), 32'd0);
    chk("a_lo_addr", 32'(mem_addr), 32'd0);
    chk("a_lo_data", 32'(mem_data), 32'h0201);
    smp(1'b1, 1'b0, 8'h00);
    smp(1'b1, 1'b1, 8'h03);
    smp(1'b1, 1'b1, 8'h04);
    chk("a_hi_bank", 32'(mem_bank), 32'd1);
    chk("a_hi_addr", 32'(mem_addr), 32'd0);
    smp(1'b1, 1'b0, 8'h00);

    // Blank fall and vsync fall on the same sample with a pending byte
    smp(1'b1, 1'b1, 8'h0A);
    smp(1'b1, 1'b1, 8'h0B);
    smp(1'b1, 1'b1, 8'h0C);
    smp(1'b0, 1'b0, 8'h00);
    chk("c_fl_we",   32'(mem_we), 32'd1);
    chk("c_fl_data", 32'(mem_data), 32'h000C);
    chk("c_fl_addr", 32'(mem_addr), 32'd2);
    chk("c_done",    32'(done), 32'd1);
    chk("c_busy",    32'(busy), 32'd0);
    chk("c_lines",   32'(lines_captured), 32'd3);

    // Reset pulse during capture with a half-formed word
    arm_and_sync();
    for (int i = 1; i <= 5; i++) smp(1'b1, 1'b1, 8'(i));
    chk("r_pre_addr", 32'(mem_addr), 32'd1);
    chk("r_pre_busy", 32'(busy), 32'd1);
    @(negedge clk);
    pix_en = 1'b1; vsync = 1'b1; vid_blank = 1'b1; video_in = 8'h06;
    reset_n = 1'b0;
    #1;
    chk("r_addr",  32'(mem_addr), 32'd0);
    chk("r_data",  32'(mem_data), 32'd0);
    chk("r_busy",  32'(busy), 32'd0);
    chk("r_bank",  32'(mem_bank), 32'd0);
    @(negedge clk);
    pix_en = 1'b0;
    chk("r_we",    32'(mem_we), 32'd0);
    chk("r_done",  32'(done), 32'd0);
    chk("r_err",   32'(frame_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("r_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
